// File: rtl/asic_oa_pipe_pkg.sv
// Shared constants for the pipelined complex-gate family (oa/ao now, aoi/oai later).
// Mode encodings travel with each transaction through the pipeline.
package asic_oa_pipe_pkg;

   localparam logic MODE_OA = 1'b0;
   localparam logic MODE_AO = 1'b1;

endpackage

// File: rtl/asic_oa_pipe_stage.sv
// Valid/data pipeline register with load enable.
// Asynchronous clear empties the stage and zeroes its payload.
module asic_oa_pipe_stage #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          i_load,
   input  logic          i_vld,
   input  logic [DW-1:0] i_data,
   output logic          o_vld,
   output logic [DW-1:0] o_data
);

   logic          r_vld;
   logic [DW-1:0] r_data;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_vld  <= 1'b0;
         r_data <= '0;
      end else if (i_load) begin
         r_vld  <= i_vld;
         r_data <= i_data;
      end
   end

   assign o_vld  = r_vld;
   assign o_data = r_data;

endmodule

// File: rtl/asic_oa_pipe.sv
// Two-stage pipelined OR-AND / AND-OR reduction over GROUPS x INPUTS x W lanes,
// behind a valid/ready handshake; mode is captured alongside the data.
module asic_oa_pipe
   import asic_oa_pipe_pkg::*;
#(
   parameter string PROP   = "DEFAULT",
   parameter int    GROUPS = 3,
   parameter int    INPUTS = 2,
   parameter int    W      = 1
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic [GROUPS*INPUTS*W-1:0] in,
   input  logic                       mode,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [W-1:0]               z,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int S1W = GROUPS*W + 1;

   logic              w_adv1;
   logic              w_adv2;
   logic [GROUPS*W-1:0] w_inner;
   logic              w_s1_v;
   logic [S1W-1:0]    w_s1_data;
   logic [GROUPS*W-1:0] w_s1_inner;
   logic              w_s1_mode;
   logic [W-1:0]      w_outer;
   logic              w_s2_v;

   // Handshake: a stage may load when it is empty or its successor is moving.
   assign w_adv2   = !w_s2_v | out_ready;
   assign w_adv1   = !w_s1_v | w_adv2;
   assign in_ready = w_adv1;

   // Stage 1 input: inner reduction within each group, per lane
   for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      for (genvar l = 0; l < W; l++) begin : g_lane
         logic [INPUTS-1:0] w_grp;
         for (genvar i = 0; i < INPUTS; i++) begin : g_in
            assign w_grp[i] = in[(g*INPUTS + i)*W + l];
         end
         assign w_inner[g*W + l] = (mode == MODE_AO) ? &w_grp : |w_grp;
      end
   end

   asic_oa_pipe_stage #(.DW(S1W)) u_s1 (
      .clk    (clk),
      .nreset (nreset),
      .i_load (w_adv1),
      .i_vld  (in_valid),
      .i_data ({mode, w_inner}),
      .o_vld  (w_s1_v),
      .o_data (w_s1_data)
   );

   assign w_s1_mode  = w_s1_data[S1W-1];
   assign w_s1_inner = w_s1_data[S1W-2:0];

   // Stage 2 input: outer reduction across groups, using the captured mode
   for (genvar l = 0; l < W; l++) begin : g_outer
      logic [GROUPS-1:0] w_col;
      for (genvar g = 0; g < GROUPS; g++) begin : g_col
         assign w_col[g] = w_s1_inner[g*W + l];
      end
      assign w_outer[l] = (w_s1_mode == MODE_AO) ? |w_col : &w_col;
   end

   asic_oa_pipe_stage #(.DW(W)) u_s2 (
      .clk    (clk),
      .nreset (nreset),
      .i_load (w_adv2),
      .i_vld  (w_s1_v),
      .i_data (w_outer),
      .o_vld  (w_s2_v),
      .o_data (z)
   );

   assign out_valid = w_s2_v;

endmodule

// File: tb/tb_asic_oa_pipe.sv
// Scoreboard bench for asic_oa_pipe: a 3x2x1 instance for directed cases
// and a 4x3x4 instance for a randomised handshake sweep.
module tb_asic_oa_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic nreset;

   logic [5:0]  a_in;
   logic        a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [0:0]  a_z;

   logic [47:0] b_in;
   logic        b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [3:0]  b_z;

   asic_oa_pipe #(.GROUPS(3), .INPUTS(2), .W(1)) dut_a (
      .clk       (clk),
      .nreset    (nreset),
      .in        (a_in),
      .mode      (a_mode),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .z         (a_z),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready)
   );

   asic_oa_pipe #(.GROUPS(4), .INPUTS(3), .W(4)) dut_b (
      .clk       (clk),
      .nreset    (nreset),
      .in        (b_in),
      .mode      (b_mode),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .z         (b_z),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int na_out = 0;
   int nb_in  = 0;
   int nb_out = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] ea, eb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Bitwise reference: OA = AND over groups of OR within group, AO = dual.
   function automatic logic [7:0] model(input logic [63:0] v, input logic m,
                                        input int g_n, input int i_n, input int w_n);
      logic [7:0] r;
      logic acc, gi, bt;
      r = '0;
      for (int l = 0; l < w_n; l++) begin
         acc = !m;
         for (int g = 0; g < g_n; g++) begin
            gi = m;
            for (int i = 0; i < i_n; i++) begin
               bt = v[(g*i_n + i)*w_n + l];
               gi = m ? (gi & bt) : (gi | bt);
            end
            acc = m ? (acc | gi) : (acc & gi);
         end
         r[l] = acc;
      end
      return r;
   endfunction

   // Scoreboard: sampled mid-cycle, so each condition predicts the next rising edge.
   always @(negedge clk) begin
      if (nreset) begin
         if (a_out_valid && a_out_ready) begin
            chk("a_q_has_item", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
               ea = qa.pop_front();
               chk("a_z", 32'(a_z), 32'(ea));
               na_out++;
            end
         end
         if (a_in_valid && a_in_ready) qa.push_back(model(64'(a_in), a_mode, 3, 2, 1));
         if (b_out_valid && b_out_ready) begin
            chk("b_q_has_item", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
               eb = qb.pop_front();
               chk("b_z", 32'(b_z), 32'(eb));
               nb_out++;
            end
         end
         if (b_in_valid && b_in_ready) begin
            qb.push_back(model(64'(b_in), b_mode, 4, 3, 4));
            nb_in++;
         end
      end
   end

   task automatic send_one(input logic [5:0] v, input logic m, input logic exp, input string tag);
      a_in = v; a_mode = m; a_in_valid = 1'b1; a_out_ready = 1'b1;
      #0 chk({tag, "_rdy"}, 32'(a_in_ready), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_lat1"}, 32'(a_out_valid), 32'd0);
      a_in_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
      chk({tag, "_z"}, 32'(a_z), 32'(exp));
   endtask

   task automatic drain_a(input string tag);
      for (int t = 0; t < 20 && qa.size() != 0; t++) @(posedge clk);
      #1 chk(tag, 32'(qa.size()), 32'd0);
   endtask

   logic [5:0] bp_in [5] = '{6'h15, 6'h2A, 6'h3F, 6'h07, 6'h30};
   logic       bp_md [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [5:0] bb_in [6] = '{6'b011001, 6'b000011, 6'b001001, 6'b010101, 6'b111111, 6'b101010};
   logic       bb_md [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      int idx, n0;
      logic acc;
      logic [0:0] zs;
      nreset = 1'b0;
      a_in = 6'b011001; a_mode = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
      b_in = '0; b_mode = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;

      // reset held with valid input
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_z", 32'(a_z), 32'd0);
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);
      nreset = 1'b1;
      send_one(6'b011001, 1'b0, 1'b1, "rst_first");

      // directed OA / AO
      send_one(6'b001001, 1'b0, 1'b0, "oa_b");
      send_one(6'b111111, 1'b0, 1'b1, "oa_c");
      send_one(6'b000011, 1'b1, 1'b1, "ao_a");
      send_one(6'b010101, 1'b1, 1'b0, "ao_b");
      @(posedge clk); #1;

      // back-to-back, alternating mode, full throughput
      for (int k = 0; k < 6; k++) begin
         a_in = bb_in[k]; a_mode = bb_md[k]; a_in_valid = 1'b1;
         @(negedge clk);
         chk("b2b_ready", 32'(a_in_ready), 32'd1);
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      drain_a("b2b_drain");

      // backpressure
      n0 = na_out;
      idx = 0;
      a_out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         a_in = bp_in[idx]; a_mode = bp_md[idx]; a_in_valid = 1'b1;
         @(negedge clk); acc = a_in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      chk("bp_accepted", 32'(idx), 32'd2);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_z_item0", 32'(a_z), 32'(model(64'(bp_in[0]), bp_md[0], 3, 2, 1)));
      zs = a_z;
      repeat (3) @(posedge clk);
      #1 chk("bp_z_stable", 32'(a_z), 32'(zs));
      a_out_ready = 1'b1;
      for (int t = 0; t < 30 && idx < 5; t++) begin
         a_in = bp_in[idx]; a_mode = bp_md[idx]; a_in_valid = 1'b1;
         @(negedge clk); acc = a_in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      a_in_valid = 1'b0;
      chk("bp_all_accepted", 32'(idx), 32'd5);
      drain_a("bp_drain");
      chk("bp_delivered", 32'(na_out - n0), 32'd5);

      // reset pulse mid-stall with two items in flight
      a_out_ready = 1'b0;
      a_in = 6'h3F; a_mode = 1'b0; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in = 6'h01; a_mode = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      chk("mid_pre_valid", 32'(a_out_valid), 32'd1);
      n0 = na_out;
      @(posedge clk); #2;
      nreset = 1'b0;
      qa.delete(); qb.delete();
      #1;
      chk("mid_out_valid", 32'(a_out_valid), 32'd0);
      chk("mid_z", 32'(a_z), 32'd0);
      chk("mid_in_ready", 32'(a_in_ready), 32'd1);
      #4 nreset = 1'b1;
      a_out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_no_stale", 32'(a_out_valid), 32'd0);
      chk("mid_no_output", 32'(na_out - n0), 32'd0);
      send_one(6'b100110, 1'b0, 1'b1, "post_rst");

      // randomised sweep on the wide instance
      for (int c = 0; c < 1000; c++) begin
         b_in = {16'($urandom), 32'($urandom)};
         b_mode = 1'($urandom_range(0, 1));
         b_in_valid = ($urandom_range(0, 3) != 0);
         b_out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0; b_out_ready = 1'b1;
      for (int t = 0; t < 20 && qb.size() != 0; t++) @(posedge clk);
      #1;
      chk("rand_drain", 32'(qb.size()), 32'd0);
      chk("rand_count", 32'(nb_out), 32'(nb_in));
      chk("rand_traffic", 32'(nb_in > 200), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/asic_oa_pipe.md
# asic_oa_pipe

Parametrised, pipelined OR-AND / AND-OR reduction gate for asiclib. It generalises the fixed three-group, two-input OR-AND cell to GROUPS groups of INPUTS inputs over W parallel bit lanes. A per-transaction mode selects product-of-sums or sum-of-products. Two registered stages sit behind a valid/ready handshake, so the block drops into datapaths that need a registered, back-pressurable complex-gate reduction.

## Interface
- PROP, "DEFAULT", implementation property string, passed through to the cell mapping.
- GROUPS, 3, number of groups (≥1).
- INPUTS, 2, inputs per group (≥1).
- W, 1, bit lanes, evaluated independently and bitwise.
- clk  input  1  clock; all state updates on the rising edge.
- nreset  input  1  asynchronous active-low reset.
- in  input  GROUPS*INPUTS*W  operands; lane w of input i of group g is in[(g*INPUTS+i)*W + w].
- mode  input  1  0 = OA, z = AND over groups of (OR within group); 1 = AO, z = OR over groups of (AND within group).
- in_valid  input  1  in and mode are valid this cycle.
- in_ready  output  1  block accepts in this cycle.
- z  output  W  result.
- out_valid  output  1  z is valid.
- out_ready  input  1  downstream accepts z this cycle.

## Operation
- Accept: on a rising edge with in_valid & in_ready.
- Stage 1 register: per group and lane, holds the inner reduction (OR for OA, AND for AO), together with mode and a valid bit s1_v.
- Stage 2 register: holds z, the outer reduction (AND for OA, OR for AO) across groups, and valid bit s2_v.
- out_valid = s2_v.
- mode is captured with its data; changing mode never affects data already in flight.
- Stage advance rules:
  - adv2 = !s2_v | out_ready.
  - adv1 = !s1_v | adv2.
  - in_ready = adv1.
  - Stage 2 loads from stage 1 when adv2; s2_v takes s1_v.
  - Stage 1 loads from in when adv1; s1_v takes in_valid.
- Stall (out_ready=0 with s2_v=1): both stages hold. in_ready=0 once s1_v=1.
- Transfers: no data dropped or duplicated; output order equals acceptance order.
- Degenerate sizes: GROUPS=1 gives a plain pipelined OR/AND per group; INPUTS=1 gives AND/OR across groups. Both are legal.
- Reset (asynchronous, any time, including mid-stall):
  - s1_v, s2_v, out_valid and z go to 0 immediately.
  - Stage 1 data and mode go to 0.
  - In-flight data is discarded.
  - in_ready becomes 1 while reset is asserted and after release.

## Timing
- Latency: an item accepted at edge N presents out_valid=1 and its z after edge N+1. It completes at edge N+2 when out_ready=1.
- Throughput: one item per cycle with out_ready held high.
- Combinational paths:
  - in_ready depends on out_ready through adv2/adv1. Integrators must not make out_ready depend on in_ready.
  - No other combinational path from inputs to outputs.
- With out_ready=1 the output stalls only when in_valid is low; bubbles pass through.

## Structure
- Mode encodings (MODE_OA=0, MODE_AO=1) are constants in the shared asiclib package, reused by future aoi/oai pipelined variants.
- One sub-module, asic_oa_pipe_stage: a width-parametrised valid/data register with load-enable and asynchronous clear. It is instantiated twice.
- The reduction logic stays in the top level as generate loops over groups and lanes.

## Test plan
All scenarios use GROUPS=3, INPUTS=2, W=1, so bit 0=a0, 1=a1, 2=b0, 3=b1, 4=c0, 5=c1.
- Reset: hold nreset=0 with in_valid=1 → out_valid=0, z=0, in_ready=1. Release → first output exactly 2 edges after first acceptance.
- OA mode, mode=0:
  - in=6'b011001 → z=1.
  - in=6'b001001 → z=0.
  - in=6'b111111 → z=1.
  - Each result appears 2 cycles after acceptance.
- AO mode, mode=1:
  - in=6'b000011 → z=1.
  - in=6'b010101 → z=0.
  - Send back-to-back while alternating mode with OA items → each z matches its own captured mode.
- Backpressure:
  - Stream 5 items with out_ready=0 → exactly 2 accepted, then in_ready=0, z stable.
  - Raise out_ready → all 5 delivered in order, no loss or duplication.
- Reset mid-stall: 2 items in flight with out_ready=0, pulse nreset low for half a cycle → out_valid drops asynchronously. No stale item appears after release.
- Width sweep: with W=4, GROUPS=4, INPUTS=3, drive 1000 random in/mode/valid/ready cycles → every output matches the bitwise OA/AO model in order.
